imm_ext_pipe: RTL and testbench

- Registered, parametrised successor to the decode-stage immediate extender.
- Decodes an instruction immediate field by format select into a DATA_W sign/zero-extended, optionally shifted operand.
- Sits between decode and the ID/EX operand mux.
- Adds a valid/ready handshake, a one-cycle output register, a flush, and an optional prefix FSM that builds full-width constants from two instructions.

---
 rtl/imm_pkg.sv | 19 +
 rtl/imm_fmt_decode.sv | 35 +++
 rtl/imm_ext_pipe.sv | 114 +++++++++++
 tb/tb_imm_ext_pipe.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared constants for the immediate extender: format selects, field width, prefix FSM states.
package imm_pkg;

  localparam int unsigned FIELD_W = 24;

  localparam int unsigned SEL_STD  = 0;
  localparam int unsigned SEL_BEQ  = 1;
  localparam int unsigned SEL_ADDI = 2;
  localparam int unsigned SEL_MOVI = 3;
  localparam int unsigned SEL_BEQZ = 4;
  localparam int unsigned SEL_JUMP = 5;
  localparam int unsigned SEL_PFX  = 6;

  typedef enum logic {
    PFX_IDLE  = 1'b0,
    PFX_ARMED = 1'b1
  } pfx_state_e;

endpackage

// File: rtl/imm_fmt_decode.sv
// Combinational immediate decode: selects the field for the format, extends to DATA_W and applies the shift.
module imm_fmt_decode #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned FIELD_W = imm_pkg::FIELD_W,
  parameter int unsigned SEL_W   = 4
) (
  input  logic [SEL_W-1:0]   sel,
  input  logic               sign_ena,
  input  logic [FIELD_W-1:0] imm_field,
  output logic [DATA_W-1:0]  base_c
);
  import imm_pkg::*;

  always_comb begin
    base_c = '0;
    case (sel)
      SEL_W'(SEL_STD):
        base_c = {{(DATA_W-5){sign_ena & imm_field[14]}}, imm_field[14:10]};
      SEL_W'(SEL_BEQ):
        base_c = {{(DATA_W-15){sign_ena & imm_field[13]}}, imm_field[13:0], 1'b0};
      SEL_W'(SEL_ADDI):
        base_c = {{(DATA_W-15){sign_ena & imm_field[14]}}, imm_field[14:0]};
      SEL_W'(SEL_MOVI):
        base_c = {{(DATA_W-20){sign_ena & imm_field[19]}}, imm_field[19:0]};
      SEL_W'(SEL_BEQZ):
        base_c = {{(DATA_W-17){sign_ena & imm_field[15]}}, imm_field[15:0], 1'b0};
      // The prefix select shares the jump decode; the top ignores base for prefix beats.
      SEL_W'(SEL_JUMP), SEL_W'(SEL_PFX):
        base_c = {{(DATA_W-25){imm_field[23]}}, imm_field[23:0], 1'b0};
      default:
        base_c = {{(DATA_W-25){imm_field[23]}}, imm_field[23:0], 1'b0};
    endcase
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// Registered immediate extender with valid/ready handshake and flush.
// Define IMM_PREFIX_EN to enable the sel-6 prefix FSM that supplies the upper result bits.
module imm_ext_pipe #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned FIELD_W = imm_pkg::FIELD_W,
  parameter int unsigned SEL_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SEL_W-1:0]   sel,
  input  logic               sign_ena,
  input  logic [FIELD_W-1:0] imm_field,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  ext_out,
  output logic               pfx_pending
);
  import imm_pkg::*;

  logic [DATA_W-1:0] base_c;
  logic [DATA_W-1:0] beat_val_c;
  logic              accept_c;
  logic              beat_c;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] ext_q, ext_d;

  imm_fmt_decode #(
    .DATA_W  (DATA_W),
    .FIELD_W (FIELD_W),
    .SEL_W   (SEL_W)
  ) u_decode (
    .sel       (sel),
    .sign_ena  (sign_ena),
    .imm_field (imm_field),
    .base_c    (base_c)
  );

  assign in_ready = !flush && (!out_valid_q || out_ready);
  assign accept_c = in_valid && in_ready;

`ifdef IMM_PREFIX_EN
  localparam int unsigned PFX_W = DATA_W - 16;

  pfx_state_e       state_q, state_d;
  logic [PFX_W-1:0] pfx_q, pfx_d;
  logic             is_pfx_c;

  assign is_pfx_c   = (sel == SEL_W'(SEL_PFX));
  assign beat_c     = accept_c && !is_pfx_c;
  assign beat_val_c = (state_q == PFX_ARMED) ? {pfx_q, base_c[15:0]} : base_c;

  // Prefix FSM: a prefix arms/overwrites, the next real beat consumes it; flush disarms.
  always_comb begin
    state_d = state_q;
    pfx_d   = pfx_q;
    if (flush) begin
      state_d = PFX_IDLE;
    end else if (accept_c) begin
      if (is_pfx_c) begin
        state_d = PFX_ARMED;
        pfx_d   = PFX_W'($signed({imm_field[15] & sign_ena, imm_field[15:0]}));
      end else begin
        state_d = PFX_IDLE;
      end
    end
  end

  assign pfx_pending = (state_q == PFX_ARMED);
`else
  assign beat_c      = accept_c;
  assign beat_val_c  = base_c;
  assign pfx_pending = 1'b0;
`endif

  // Output register: load on a real beat, drain on out_ready, hold otherwise.
  always_comb begin
    out_valid_d = out_valid_q;
    ext_d       = ext_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (beat_c) begin
      out_valid_d = 1'b1;
      ext_d       = beat_val_c;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      ext_q       <= '0;
`ifdef IMM_PREFIX_EN
      state_q     <= PFX_IDLE;
      pfx_q       <= '0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      ext_q       <= ext_d;
`ifdef IMM_PREFIX_EN
      state_q     <= state_d;
      pfx_q       <= pfx_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign ext_out   = ext_q;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Scoreboard bench for imm_ext_pipe: directed beats push expected values, a monitor pops on each output transfer.
module tb_imm_ext_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  sel;
  logic        sign_ena;
  logic [23:0] imm_field;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ext_out;
  logic        pfx_pending;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  imm_ext_pipe #(.DATA_W(32), .FIELD_W(24), .SEL_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .sel         (sel),
    .sign_ena    (sign_ena),
    .imm_field   (imm_field),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .ext_out     (ext_out),
    .pfx_pending (pfx_pending)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every output transfer must match the oldest expected value.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_beat: got %h want none at %0t", ext_out, $time);
      end else begin
        check("beat", ext_out, exp_q.pop_front());
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [3:0] s, input logic se, input logic [23:0] imm,
                      input logic [31:0] exp_v, input bit push);
    bit took = 1'b0;
    int n = 0;
    in_valid  = 1'b1;
    sel       = s;
    sign_ena  = se;
    imm_field = imm;
    while (!took && n < 50) begin
      @(negedge clk);
      took = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    check("accept", 32'(took), 32'd1);
    if (took && push) exp_q.push_back(exp_v);
  endtask

  task automatic single(input logic [3:0] s, input logic se, input logic [23:0] imm,
                        input logic [31:0] exp_v);
    send(s, se, imm, exp_v, 1'b1);
    @(negedge clk);
    check("latency", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    sel       = 4'd0;
    sign_ena  = 1'b0;
    imm_field = 24'h0;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_ext_out", ext_out, 32'h0);
    check("rst_pfx", 32'(pfx_pending), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Format table vectors
    single(4'd2, 1'b1, 24'h004000, 32'hFFFFC000);
    single(4'd2, 1'b0, 24'h004000, 32'h00004000);
    single(4'd1, 1'b1, 24'h002001, 32'hFFFFC002);
    single(4'd5, 1'b0, 24'h800000, 32'hFF000000);
    single(4'd9, 1'b0, 24'h800000, 32'hFF000000);
    single(4'd15, 1'b0, 24'h000003, 32'h00000006);
    single(4'd0, 1'b1, 24'h004000, 32'hFFFFFFF0);
    single(4'd0, 1'b0, 24'h007C00, 32'h0000001F);
    single(4'd3, 1'b1, 24'h080000, 32'hFFF80000);
    single(4'd4, 1'b1, 24'h008000, 32'hFFFF0000);
    single(4'd4, 1'b0, 24'h008000, 32'h00010000);

    // Backpressure: result held, second beat stalled until out_ready
    out_ready = 1'b0;
    send(4'd2, 1'b0, 24'h000005, 32'h00000005, 1'b1);
    fork
      send(4'd2, 1'b0, 24'h000007, 32'h00000007, 1'b1);
      begin
        repeat (3) begin
          @(negedge clk);
          check("bp_valid", 32'(out_valid), 32'd1);
          check("bp_hold", ext_out, 32'h00000005);
          check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    @(negedge clk);
    check("bp_second_valid", 32'(out_valid), 32'd1);
    check("bp_second", ext_out, 32'h00000007);
    @(posedge clk);
    #1;

`ifdef IMM_PREFIX_EN
    // Prefix builds the upper half, next beat supplies the lower half
    send(4'd6, 1'b1, 24'h00ABCD, 32'h0, 1'b0);
    @(negedge clk);
    check("pfx_no_beat", 32'(out_valid), 32'd0);
    check("pfx_armed", 32'(pfx_pending), 32'd1);
    @(posedge clk);
    #1;
    single(4'd2, 1'b1, 24'h001234, 32'hABCD1234);
    check("pfx_consumed", 32'(pfx_pending), 32'd0);

    // Flush disarms the prefix
    send(4'd6, 1'b1, 24'h00ABCD, 32'h0, 1'b0);
`else
    // sel 6 decodes as jump when the prefix feature is absent
    single(4'd6, 1'b0, 24'h800000, 32'hFF000000);
    check("no_pfx_pending", 32'(pfx_pending), 32'd0);

    // Flush drops a stalled output beat
    out_ready = 1'b0;
    send(4'd2, 1'b0, 24'h000055, 32'h0, 1'b0);
`endif
    flush     = 1'b1;
    in_valid  = 1'b1;
    sel       = 4'd2;
    imm_field = 24'h000099;
    @(negedge clk);
    check("flush_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_pfx", 32'(pfx_pending), 32'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("flush_dropped", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    single(4'd2, 1'b1, 24'h001234, 32'h00001234);

    // Asynchronous reset mid-cycle discards armed prefix / pending output
`ifdef IMM_PREFIX_EN
    send(4'd6, 1'b1, 24'h00ABCD, 32'h0, 1'b0);
`else
    out_ready = 1'b0;
    send(4'd2, 1'b0, 24'h000077, 32'h0, 1'b0);
`endif
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_ext", ext_out, 32'h0);
    check("arst_pfx", 32'(pfx_pending), 32'd0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    single(4'd2, 1'b1, 24'h001234, 32'h00001234);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
